// File: rtl/burrito_pkg.sv
// Shared definitions for the burrito_segmentado datapath.
// Holds the ALU opcode type, default widths and the instruction field layout
// {rs1, rs2, rd, op}, with the op field in the low bits.
package burrito_pkg;

  localparam int unsigned ANCHO_DEF    = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned OP_W         = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } op_t;

  // Instruction layout helpers, given the register address width.
  function automatic int unsigned instr_width(input int unsigned dir);
    return 3 * dir + OP_W;
  endfunction

  function automatic int unsigned rs1_lsb(input int unsigned dir);
    return 2 * dir + OP_W;
  endfunction

  function automatic int unsigned rs2_lsb(input int unsigned dir);
    return dir + OP_W;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned dir);
    return OP_W + 0 * dir;
  endfunction

endpackage

// File: rtl/alu_burrito.sv
// Combinational ALU for burrito_segmentado.
// Ports:
//   a, b : operands (ANCHO bits)
//   op   : operation select (op_t)
//   y    : result, modulo 2^ANCHO
module alu_burrito
  import burrito_pkg::*;
#(
  parameter int unsigned ANCHO = ANCHO_DEF
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  op_t              op,
  output logic [ANCHO-1:0] y
);

  localparam int unsigned SH = $clog2(ANCHO);

  logic [SH-1:0] shamt;
  logic          lt;

  // Shift amount is taken modulo ANCHO.
  assign shamt = b[SH-1:0];
  assign lt    = $signed(a) < $signed(b);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_SUB:  y = a - b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(ANCHO-1){1'b0}}, lt};
      OP_SLL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/burrito_segmentado.sv
// Three-stage pipelined register-file + ALU datapath.
// S1 holds the accepted instruction and reads the register file, S2 executes
// in alu_burrito, S3 holds the retired result; REG[rd] is written as S2 retires.
// Optional macro BURRITO_BYPASS_EN: forward the S2 result into S1 on a RAW
// hazard instead of stalling S1 for one cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   instruccion         : {rs1, rs2, rd, op}
//   valido_in/listo_out : input handshake
//   carga_en/dir/dato   : direct register-file load port
//   resultado, dir_out  : retired result and destination register
//   valido_out          : one-cycle pulse per retired instruction
module burrito_segmentado
  import burrito_pkg::*;
#(
  parameter  int unsigned ANCHO    = ANCHO_DEF,
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned DIR      = $clog2(NUM_REGS),
  localparam int unsigned IW       = instr_width(DIR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    instruccion,
  input  logic             valido_in,
  output logic             listo_out,
  input  logic             carga_en,
  input  logic [DIR-1:0]   carga_dir,
  input  logic [ANCHO-1:0] carga_dato,
  output logic [ANCHO-1:0] resultado,
  output logic [DIR-1:0]   dir_out,
  output logic             valido_out
);

  localparam int unsigned RS1_LSB = rs1_lsb(DIR);
  localparam int unsigned RS2_LSB = rs2_lsb(DIR);
  localparam int unsigned RD_LSB  = rd_lsb(DIR);

  logic             s1_valid_q, s1_valid_d;
  logic [IW-1:0]    s1_instr_q, s1_instr_d;
  logic [DIR-1:0]   s1_rs1, s1_rs2, s1_rd;
  op_t              s1_op;
  logic [ANCHO-1:0] s1_a, s1_b;

  logic             s2_valid_q, s2_valid_d;
  logic [ANCHO-1:0] s2_a_q, s2_a_d;
  logic [ANCHO-1:0] s2_b_q, s2_b_d;
  logic [DIR-1:0]   s2_rd_q, s2_rd_d;
  op_t              s2_op_q, s2_op_d;
  logic [ANCHO-1:0] alu_y;

  logic [ANCHO-1:0] res_q, res_d;
  logic [DIR-1:0]   dir_q, dir_d;
  logic             vout_q, vout_d;

  logic [ANCHO-1:0] reg_q [NUM_REGS];

  logic haz_rs1, haz_rs2, stall, accept;

  assign s1_rs1 = s1_instr_q[RS1_LSB +: DIR];
  assign s1_rs2 = s1_instr_q[RS2_LSB +: DIR];
  assign s1_rd  = s1_instr_q[RD_LSB +: DIR];
  assign s1_op  = op_t'(s1_instr_q[OP_W-1:0]);

  // The only RAW window: S2 has not written its rd yet while S1 reads it.
  assign haz_rs1 = s1_valid_q & s2_valid_q & (s2_rd_q == s1_rs1);
  assign haz_rs2 = s1_valid_q & s2_valid_q & (s2_rd_q == s1_rs2);

`ifdef BURRITO_BYPASS_EN
  assign s1_a  = haz_rs1 ? alu_y : reg_q[s1_rs1];
  assign s1_b  = haz_rs2 ? alu_y : reg_q[s1_rs2];
  assign stall = 1'b0;
`else
  assign s1_a  = reg_q[s1_rs1];
  assign s1_b  = reg_q[s1_rs2];
  assign stall = haz_rs1 | haz_rs2;
`endif

  assign listo_out = ~stall;
  assign accept    = valido_in & listo_out;

  alu_burrito #(
    .ANCHO (ANCHO)
  ) u_alu (
    .a  (s2_a_q),
    .b  (s2_b_q),
    .op (s2_op_q),
    .y  (alu_y)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s2_valid_d = 1'b0;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    s2_rd_d    = s2_rd_q;
    s2_op_d    = s2_op_q;
    if (!stall) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_instr_d = instruccion;
      end
      s2_valid_d = s1_valid_q;
      s2_a_d     = s1_a;
      s2_b_d     = s1_b;
      s2_rd_d    = s1_rd;
      s2_op_d    = s1_op;
    end
    // On a stall S1 holds and a bubble (s2_valid_d = 0) enters S2.
  end

  always_comb begin
    vout_d = s2_valid_q;
    res_d  = res_q;
    dir_d  = dir_q;
    if (s2_valid_q) begin
      res_d = alu_y;
      dir_d = s2_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_rd_q    <= '0;
      s2_op_q    <= OP_ADD;
      vout_q     <= 1'b0;
      res_q      <= '0;
      dir_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s2_valid_q <= s2_valid_d;
      s2_a_q     <= s2_a_d;
      s2_b_q     <= s2_b_d;
      s2_rd_q    <= s2_rd_d;
      s2_op_q    <= s2_op_d;
      vout_q     <= vout_d;
      res_q      <= res_d;
      dir_q      <= dir_d;
    end
  end

  // Register file. The load port is written last so it wins a same-edge
  // conflict with the S2 writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
    end else begin
      if (s2_valid_q) begin
        reg_q[s2_rd_q] <= alu_y;
      end
      if (carga_en) begin
        reg_q[carga_dir] <= carga_dato;
      end
    end
  end

  assign resultado  = res_q;
  assign dir_out    = dir_q;
  assign valido_out = vout_q;

endmodule

// File: tb/tb_burrito_segmentado.sv
module tb_burrito_segmentado;
  import burrito_pkg::*;

  localparam int ANCHO    = 32;
  localparam int NUM_REGS = 32;
  localparam int DIR      = 5;
  localparam int IW       = 18;
`ifdef BURRITO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          dir;
    logic [31:0] res;
    int          cyc;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [IW-1:0]    instruccion;
  logic             valido_in;
  logic             listo_out;
  logic             carga_en;
  logic [DIR-1:0]   carga_dir;
  logic [ANCHO-1:0] carga_dato;
  logic [ANCHO-1:0] resultado;
  logic [DIR-1:0]   dir_out;
  logic             valido_out;

  burrito_segmentado #(
    .ANCHO    (ANCHO),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instruccion (instruccion),
    .valido_in   (valido_in),
    .listo_out   (listo_out),
    .carga_en    (carga_en),
    .carga_dir   (carga_dir),
    .carga_dato  (carga_dato),
    .resultado   (resultado),
    .dir_out     (dir_out),
    .valido_out  (valido_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Architectural reference: register values in program order, expected
  // retirement stream, and the timing rule "a consumer accepted on the edge
  // its producer leaves S1 waits one extra cycle unless forwarding exists".
  logic [31:0] mreg [32];
  ev_t obs[$];
  ev_t exp_q[$];
  int prev_leave = -100;
  int prev_rd    = -1;
  int exp_stalls = 0;
  int lo_cnt     = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (valido_out) begin
        ev_t e;
        e.dir = int'(dir_out);
        e.res = resultado;
        e.cyc = cyc;
        obs.push_back(e);
      end
      if (!listo_out) lo_cnt <= lo_cnt + 1;
    end
  end

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input op_t op);
    case (op)
      OP_ADD:  return a + b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLL:  return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (6) step();
  endtask

  task automatic load(input int d, input logic [31:0] v);
    carga_en   = 1'b1;
    carga_dir  = 5'(d);
    carga_dato = v;
    step();
    carga_en   = 1'b0;
    mreg[d]    = v;
  endtask

  // Presents an instruction and leaves valido_in high; returns the accept edge.
  task automatic issue(input int rs1, input int rs2, input int rd, input op_t op,
                       output int acc);
    int budget;
    int haz;
    int leave;
    ev_t e;
    budget      = 20;
    instruccion = {5'(rs1), 5'(rs2), 5'(rd), op};
    valido_in   = 1'b1;
    while (!listo_out && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: listo_out=%0b required 1 within 20 cycles", listo_out);
    end
    step();
    acc   = cyc;
    haz   = (!BYP && prev_leave == acc && (rs1 == prev_rd || rs2 == prev_rd)) ? 1 : 0;
    leave = acc + 1 + haz;
    e.dir = rd;
    e.res = alu_ref(mreg[rs1], mreg[rs2], op);
    e.cyc = leave + 1;
    exp_q.push_back(e);
    mreg[rd]   = e.res;
    prev_leave = leave;
    prev_rd    = rd;
    exp_stalls += haz;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    foreach (mreg[i]) mreg[i] = '0;
    prev_leave = -100;
    checks++;
    if (listo_out !== 1'b1) begin
      errors++; $display("FAIL reset_listo: got %0b want 1", listo_out);
    end
    checks++;
    if (valido_out !== 1'b0) begin
      errors++; $display("FAIL reset_valido: got %0b want 0", valido_out);
    end
    checks++;
    if (resultado !== 32'd0) begin
      errors++; $display("FAIL reset_resultado: got %0h want 0", resultado);
    end
    checks++;
    if (dir_out !== 5'd0) begin
      errors++; $display("FAIL reset_dir: got %0d want 0", dir_out);
    end
  endtask

  task automatic test_pipeline();
    int a0, a1, a2;
    int exp_dir [3];
    logic [31:0] exp_res [3];
    exp_dir = '{2, 5, 8};
    exp_res = '{32'd12, 32'h00F0, 32'h3};
    load(0, 32'd5);
    load(1, 32'd7);
    load(3, 32'hF0F0);
    load(4, 32'h0FF0);
    load(6, 32'h1);
    load(7, 32'h2);
    obs.delete();
    issue(0, 1, 2, OP_ADD, a0);
    issue(3, 4, 5, OP_AND, a1);
    issue(6, 7, 8, OP_OR, a2);
    valido_in = 1'b0;
    drain();
    checks++;
    if (obs.size() != 3) begin
      errors++; $display("FAIL pipe_count: got %0d want 3", obs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i].dir != exp_dir[i] || obs[i].res !== exp_res[i] || obs[i].cyc != a0 + 2 + i)
        begin
          errors++;
          $display("FAIL pipe_%0d: got dir=%0d res=%0h cyc=%0d want dir=%0d res=%0h cyc=%0d",
                   i, obs[i].dir, obs[i].res, obs[i].cyc, exp_dir[i], exp_res[i], a0 + 2 + i);
        end
      end
    end
  endtask

  task automatic test_raw();
    int a0, a1, lo0, want_cyc, want_lo;
    obs.delete();
    lo0 = lo_cnt;
    issue(0, 1, 2, OP_ADD, a0);
    issue(2, 1, 9, OP_SUB, a1);
    valido_in = 1'b0;
    drain();
    want_cyc = a0 + (BYP ? 3 : 4);
    want_lo  = BYP ? 0 : 1;
    checks++;
    if (obs.size() != 2) begin
      errors++; $display("FAIL raw_count: got %0d want 2", obs.size());
    end else begin
      checks++;
      if (obs[1].dir != 9 || obs[1].res !== 32'd5 || obs[1].cyc != want_cyc) begin
        errors++;
        $display("FAIL raw_result: got dir=%0d res=%0h cyc=%0d want dir=9 res=5 cyc=%0d",
                 obs[1].dir, obs[1].res, obs[1].cyc, want_cyc);
      end
    end
    checks++;
    if (lo_cnt - lo0 != want_lo) begin
      errors++; $display("FAIL raw_listo_drop: got %0d cycles want %0d", lo_cnt - lo0, want_lo);
    end
  endtask

  task automatic test_stall_hold();
    int a0, a1, a2, n15;
    obs.delete();
    issue(0, 1, 2, OP_ADD, a0);
    issue(2, 1, 9, OP_SUB, a1);
    issue(0, 1, 15, OP_XOR, a2);
    valido_in = 1'b0;
    drain();
    n15 = 0;
    foreach (obs[i]) if (obs[i].dir == 15) n15++;
    checks++;
    if (obs.size() != 3 || n15 != 1) begin
      errors++; $display("FAIL hold_once: got %0d pulses (%0d for R15) want 3 (1)",
                         obs.size(), n15);
    end
    checks++;
    if (a2 != a0 + (BYP ? 2 : 3)) begin
      errors++; $display("FAIL hold_accept: got edge %0d want %0d", a2, a0 + (BYP ? 2 : 3));
    end
    checks++;
    if (obs.size() == 3 && obs[2].res !== 32'd2) begin
      errors++; $display("FAIL hold_result: got %0h want 2", obs[2].res);
    end
  endtask

  task automatic test_edge();
    int a;
    logic [31:0] want [4];
    want = '{32'd0, 32'd2, 32'd1, 32'd8};
    load(1, 32'hFFFF_FFFF);
    load(0, 32'd1);
    load(10, 32'd35);
    obs.delete();
    issue(1, 0, 11, OP_ADD, a);
    issue(0, 1, 12, OP_SUB, a);
    issue(1, 0, 13, OP_SLT, a);
    issue(0, 10, 14, OP_SLL, a);
    valido_in = 1'b0;
    drain();
    checks++;
    if (obs.size() != 4) begin
      errors++; $display("FAIL edge_count: got %0d want 4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs[i].res !== want[i] || obs[i].dir != 11 + i) begin
          errors++; $display("FAIL edge_%0d: got dir=%0d res=%0h want dir=%0d res=%0h",
                             i, obs[i].dir, obs[i].res, 11 + i, want[i]);
        end
      end
    end
  endtask

  task automatic test_conflict();
    int a;
    load(0, 32'd5);
    load(1, 32'd7);
    obs.delete();
    issue(0, 1, 2, OP_ADD, a);
    valido_in = 1'b0;
    step();
    load(2, 32'hAA);  // lands on the ADD writeback edge
    issue(2, 2, 20, OP_OR, a);
    valido_in = 1'b0;
    drain();
    checks++;
    if (obs.size() != 2 || obs[0].res !== 32'd12 || obs[1].res !== 32'hAA) begin
      errors++;
      $display("FAIL conflict: got %0d pulses last res=%0h want 2 pulses add=c read=aa",
               obs.size(), (obs.size() > 0) ? obs[obs.size()-1].res : 32'hx);
    end
  endtask

  task automatic test_rst_inflight();
    int a;
    issue(0, 1, 2, OP_ADD, a);
    issue(3, 4, 5, OP_XOR, a);
    issue(1, 1, 6, OP_OR, a);
    valido_in = 1'b0;
    rst = 1'b1;
    step();
    obs.delete();
    step();
    rst = 1'b0;
    step();
    foreach (mreg[i]) mreg[i] = '0;
    prev_leave = -100;
    checks++;
    if (listo_out !== 1'b1) begin
      errors++; $display("FAIL rst_listo: got %0b want 1", listo_out);
    end
    drain();
    checks++;
    if (obs.size() != 0) begin
      errors++; $display("FAIL rst_no_output: got %0d pulses want 0", obs.size());
    end
    obs.delete();
    for (int i = 0; i < 32; i++) issue(i, i, i, OP_OR, a);
    valido_in = 1'b0;
    drain();
    checks++;
    if (obs.size() != 32) begin
      errors++; $display("FAIL rst_readback_count: got %0d want 32", obs.size());
    end else begin
      foreach (obs[i]) begin
        checks++;
        if (obs[i].res !== 32'd0 || obs[i].dir != i) begin
          errors++; $display("FAIL rst_reg_%0d: got dir=%0d res=%0h want dir=%0d res=0",
                             i, obs[i].dir, obs[i].res, i);
        end
      end
    end
  endtask

  task automatic test_random();
    int a, lo0;
    for (int i = 0; i < 32; i++) load(i, $urandom());
    load(9, 32'd33);
    obs.delete();
    exp_q.delete();
    exp_stalls = 0;
    lo0 = lo_cnt;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        valido_in = 1'b0;
        step();
      end
      issue($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
            op_t'($urandom_range(0, 7)), a);
    end
    valido_in = 1'b0;
    drain();
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", obs.size(), exp_q.size());
    end else begin
      foreach (obs[i]) begin
        checks++;
        if (obs[i].dir != exp_q[i].dir || obs[i].res !== exp_q[i].res ||
            obs[i].cyc != exp_q[i].cyc) begin
          errors++;
          $display("FAIL rand_%0d: got dir=%0d res=%0h cyc=%0d want dir=%0d res=%0h cyc=%0d",
                   i, obs[i].dir, obs[i].res, obs[i].cyc,
                   exp_q[i].dir, exp_q[i].res, exp_q[i].cyc);
        end
      end
    end
    checks++;
    if (lo_cnt - lo0 != exp_stalls) begin
      errors++; $display("FAIL rand_stalls: got %0d want %0d", lo_cnt - lo0, exp_stalls);
    end
  endtask

  initial begin
    rst         = 1'b1;
    instruccion = '0;
    valido_in   = 1'b0;
    carga_en    = 1'b0;
    carga_dir   = '0;
    carga_dato  = '0;
    test_reset();
    test_pipeline();
    test_raw();
    test_stall_hold();
    test_edge();
    test_conflict();
    test_rst_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burrito_segmentado.md
Name: burrito_segmentado

Overview:
- Parametrised, pipelined successor to the single-cycle register-bank + ALU datapath.
- Accepts one 3-operand instruction {rs1, rs2, rd, op} per cycle under a valid/ready handshake, reads two registers, executes one of eight ALU ops and writes the result back.
- Includes a bench/boot load port for the register file and RAW-hazard handling.

Parameters:
- ANCHO, 32, datapath and register width in bits (≥8).
- NUM_REGS, 32, register count; power of two, ≥2.
- DIR (localparam), $clog2(NUM_REGS), register address width.
- IW (localparam), 3*DIR+3, instruction width (18 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instruccion  in  IW  {rs1[IW-1 -: DIR], rs2, rd, op[2:0]}.
- valido_in  in  1  instruccion valid.
- listo_out  out  1  block can accept; transfer on valido_in & listo_out.
- carga_en  in  1  direct register-file write.
- carga_dir  in  DIR  load address.
- carga_dato  in  ANCHO  load data.
- resultado  out  ANCHO  retired result.
- dir_out  out  DIR  rd of retired instruction.
- valido_out  out  1  resultado/dir_out valid (one-cycle pulse per instruction).

Behaviour:
- Reset (synchronous, active-high): all registers = 0; S1/S2/S3 valid flags cleared; resultado = 0, dir_out = 0, valido_out = 0, listo_out = 1 the cycle after rst falls. rst mid-operation discards all in-flight instructions; no writeback.
- Pipeline:
  - S1 captures the accepted instruction at edge k.
  - S1 reads rs1/rs2 combinationally; operands plus rd/op are registered into S2 at edge k+1.
  - S2 ALU result is registered into S3 and written to REG[rd] at edge k+2.
  - valido_out is high in the cycle after edge k+2 (latency 3 edges). Throughput is 1 instruction/cycle absent hazards.
- ALU ops; all results are modulo 2^ANCHO:
  - 000 ADD, 001 AND, 010 OR, 011 SUB (rs1-rs2), 100 XOR.
  - 101 SLT: signed, result 1 or 0 zero-extended.
  - 110 SLL, 111 SRL: shift amount = rs2[$clog2(ANCHO)-1:0].
- Hazard: only window is S1 reading a register that the valid S2 instruction writes (rd == rs1 or rs2). A producer in S3 has already written the file. Handling depends on BYPASS_EN.
- No output backpressure; bubbles give valido_out = 0 with resultado holding its last value.
- R0 is an ordinary writable register.
- Load port:
  - Writes REG[carga_dir] at the clock edge.
  - If carga_en and an S2 writeback target the same register on the same edge, the load wins.
  - Loads are not hazard-tracked: an S1 read in the same cycle sees the old value.
- valido_in with listo_out = 0: the instruction is not taken. The source must hold it.

Optional Feature:
- Macro BURRITO_BYPASS_EN.
- Defined: the S2 ALU output is forwarded combinationally into the S1 operand mux on hazard. listo_out is then always 1 outside reset, and dependent back-to-back instructions issue every cycle.
- Undefined: on hazard, S1 holds, a bubble is inserted into S2, and listo_out = 0 for exactly that cycle, so a dependent pair gets one extra cycle of latency.
- Architectural results are identical with or without the macro.

Decomposition:
- Package burrito_pkg holds:
  - opcode constants OP_ADD..OP_SRL (3-bit typedef op_t);
  - field-slicing helpers/constants for the instruction layout;
  - default width constants.
- Sub-module alu_burrito: combinational, parametrised by ANCHO; inputs a, b, op; output y. Instantiated in S2.

Test Plan:
- Load R0=5, R1=7, R3=0xF0F0, R4=0x0FF0, R6=0x1, R7=0x2. Issue {0,1,2,ADD}, {3,4,5,AND}, {6,7,8,OR} on consecutive cycles:
  - valido_out on 3 consecutive cycles with dir_out=2/5/8 and resultado=12 / 0x00F0 / 0x3;
  - first result 3 edges after acceptance.
- RAW pair R0=5, R1=7: {0,1,2,ADD} then {2,1,9,SUB}:
  - R9=5;
  - with BYPASS_EN, no listo_out drop;
  - without it, listo_out=0 for exactly one cycle and the second result arrives 1 cycle later.
- Edge arithmetic, R1=0xFFFFFFFF, R0=1: ADD → 0; SUB(R0,R1) → 2; SLT(R1,R0) → 1; SLL(R0 by R10=35) → 0x8 (amount 35 mod 32 = 3).
- rst asserted while 3 instructions are in flight: no valido_out afterwards, all registers read back 0, listo_out=1 after release.
- Same-edge conflict: carga_en writing R2=0xAA on the same edge an ADD writeback targets R2: R2 reads 0xAA afterwards.
- Stall hold, without BYPASS_EN: hold valido_in high across the listo_out=0 cycle; the instruction is accepted exactly once (one valido_out pulse).
